// File: rtl/control_multiciclo.sv
// rtl/control_multiciclo.sv - multicycle MIPS-style control FSM
// Moore outputs are registered alongside the state; only ir_write/pc_write in FETCH are qualified by mem_ready.
module control_multiciclo #(
   parameter int USE_MEM_READY = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] opcode,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       pc_write_cond,
   output logic       i_or_d,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       mem_to_reg,
   output logic       reg_dst,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [1:0] pc_source,
   output logic [3:0] estado
);

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_J    = 6'b000010;

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_EXEC    = 4'd6,
      S_ALUWB   = 4'd7,
      S_BRANCH  = 4'd8,
      S_ADDIEX  = 4'd9,
      S_ADDIWB  = 4'd10,
      S_JUMP    = 4'd11,
      S_ILLEGAL = 4'd12
   } state_t;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_source;
   } ctrl_t;

   state_t state_q, state_d;
   ctrl_t  ctrl_q;
   logic   mem_rdy;
   logic   fetch_go;

   assign mem_rdy = (USE_MEM_READY == 0) ? 1'b1 : mem_ready;

   // FETCH's pc_write is mem_ready-qualified, so it is not part of the registered word
   function automatic ctrl_t state_ctrl(input state_t s);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH:  begin c.mem_read = 1'b1; c.alu_src_b = 2'b01; end
         S_DECODE: c.alu_src_b = 2'b11;
         S_MEMADR, S_ADDIEX: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
         S_MEMRD:  begin c.i_or_d = 1'b1; c.mem_read = 1'b1; end
         S_MEMWB:  begin c.mem_to_reg = 1'b1; c.reg_write = 1'b1; end
         S_MEMWR:  begin c.i_or_d = 1'b1; c.mem_write = 1'b1; end
         S_EXEC:   begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
         S_ALUWB:  begin c.reg_dst = 1'b1; c.reg_write = 1'b1; end
         S_BRANCH: begin
            c.alu_src_a     = 1'b1;
            c.alu_op        = 2'b01;
            c.pc_source     = 2'b01;
            c.pc_write_cond = 1'b1;
         end
         S_ADDIWB: c.reg_write = 1'b1;
         S_JUMP:   begin c.pc_source = 2'b10; c.pc_write = 1'b1; end
         default:  c = '0;
      endcase
      return c;
   endfunction

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH:  if (mem_rdy) state_d = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_R:         state_d = S_EXEC;
               OP_BEQ:       state_d = S_BRANCH;
               OP_ADDI:      state_d = S_ADDIEX;
               OP_J:         state_d = S_JUMP;
               default:      state_d = S_ILLEGAL;
            endcase
         end
         S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD:  if (mem_rdy) state_d = S_MEMWB;
         S_MEMWR:  if (mem_rdy) state_d = S_FETCH;
         S_EXEC:   state_d = S_ALUWB;
         S_ADDIEX: state_d = S_ADDIWB;
         S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: state_d = S_FETCH;
         S_ILLEGAL: state_d = S_ILLEGAL;
         default:  state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_FETCH;
         ctrl_q  <= state_ctrl(S_FETCH);
      end else begin
         state_q <= state_d;
         ctrl_q  <= state_ctrl(state_d);
      end
   end

   assign fetch_go = (state_q == S_FETCH) & mem_rdy;

   // Reset masks every output immediately, including the cycle before the first edge
   assign pc_write      = ~rst & (ctrl_q.pc_write | fetch_go);
   assign ir_write      = ~rst & fetch_go;
   assign pc_write_cond = ~rst & ctrl_q.pc_write_cond;
   assign i_or_d        = ~rst & ctrl_q.i_or_d;
   assign mem_read      = ~rst & ctrl_q.mem_read;
   assign mem_write     = ~rst & ctrl_q.mem_write;
   assign mem_to_reg    = ~rst & ctrl_q.mem_to_reg;
   assign reg_dst       = ~rst & ctrl_q.reg_dst;
   assign reg_write     = ~rst & ctrl_q.reg_write;
   assign alu_src_a     = ~rst & ctrl_q.alu_src_a;
   assign alu_src_b     = rst ? 2'b00 : ctrl_q.alu_src_b;
   assign alu_op        = rst ? 2'b00 : ctrl_q.alu_op;
   assign pc_source     = rst ? 2'b00 : ctrl_q.pc_source;
   assign estado        = rst ? 4'd0 : state_q;

endmodule
